// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern detector.
// Optional compare mask is enabled by SEQ_DET_MASK_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SCAN = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_HIT    = 2'd1;
  localparam logic [1:0] EV_RETRIG = 2'd2;
  localparam logic [1:0] EV_EXPIRE = 2'd3;

endpackage

// File: rtl/seq_det_hist.sv
// Symbol history, fill counter and pattern comparator.
// SEQ_DET_MASK_EN adds cfg_mask (1 = don't-care bit).
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 1,
  parameter int PAT_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     accept,
  input  logic                     ovl,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic [PAT_LEN*SYM_W-1:0] cfg_pat,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN*SYM_W-1:0] cfg_mask,
`endif
  output logic                     m,
  output logic                     full_nxt
);

  localparam int HW = PAT_LEN * SYM_W;
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] F_MAX = FW'(PAT_LEN);

  logic [HW-1:0] hist_q, hist_d, hist_sh, diff;
  logic [FW-1:0] fill_q, fill_d, fill_inc;

  always_comb begin
    hist_sh  = {hist_q[HW-SYM_W-1:0], i_sym};
    fill_inc = (fill_q == F_MAX) ? fill_q : fill_q + 1'b1;
    full_nxt = (fill_inc == F_MAX);
`ifdef SEQ_DET_MASK_EN
    diff     = (hist_sh ^ cfg_pat) & ~cfg_mask;
`else
    diff     = hist_sh ^ cfg_pat;
`endif
    m        = accept && full_nxt && (diff == '0);
    hist_d   = hist_q;
    fill_d   = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      // Non-overlap mode restarts the search from an empty window
      if (m && !ovl) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_sh;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_fsm.sv
// Pattern detector top: FSM, hold timer, registered outputs.
// SEQ_DET_MASK_EN adds the cfg_mask don't-care input.
module seq_det_fsm
  import seq_det_pkg::*;
#(
  parameter int SYM_W    = 1,
  parameter int PAT_LEN  = 4,
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     i_vld,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic [PAT_LEN*SYM_W-1:0] cfg_pat,
  input  logic                     cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN*SYM_W-1:0] cfg_mask,
`endif
  output logic                     o_hit,
  output logic                     o_flag,
  output logic [1:0]               o_code,
  output logic [CNT_W-1:0]         o_cnt,
  output logic [1:0]               o_state
);

  localparam int HCW = $clog2(HOLD_CYC + 1);
  localparam logic [HCW-1:0] H_LOAD = HCW'(HOLD_CYC);
  localparam logic [HCW-1:0] H_ONE  = HCW'(1);

  state_e           state_q, state_d;
  logic [HCW-1:0]   h_q, h_d;
  logic             hit_q, hit_d;
  logic             flag_q, flag_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             accept, flush, m, full_nxt;

  assign accept = en && !clr && i_vld && (state_q != ST_IDLE);
  assign flush  = !en || clr || (state_q == ST_IDLE);

  seq_det_hist #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .accept   (accept),
    .ovl      (cfg_overlap),
    .i_sym    (i_sym),
    .cfg_pat  (cfg_pat),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask (cfg_mask),
`endif
    .m        (m),
    .full_nxt (full_nxt)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    hit_d   = 1'b0;
    flag_d  = flag_q;
    code_d  = EV_NONE;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      h_d     = '0;
      flag_d  = 1'b0;
    end else if (clr) begin
      state_d = ST_FILL;
      h_d     = '0;
      flag_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL, ST_SCAN: begin
          if (accept && m) begin
            state_d = ST_HOLD;
            h_d     = H_LOAD;
            flag_d  = 1'b1;
            hit_d   = 1'b1;
            code_d  = EV_HIT;
            cnt_d   = cnt_inc;
          end else if (accept && full_nxt) begin
            state_d = ST_SCAN;
          end
        end
        ST_HOLD: begin
          // A hit on the expiring symbol retriggers instead
          if (accept && m) begin
            h_d    = H_LOAD;
            hit_d  = 1'b1;
            code_d = EV_RETRIG;
            cnt_d  = cnt_inc;
          end else if (accept && (h_q <= H_ONE)) begin
            h_d     = '0;
            flag_d  = 1'b0;
            code_d  = EV_EXPIRE;
            state_d = full_nxt ? ST_SCAN : ST_FILL;
          end else if (accept) begin
            h_d = h_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      hit_q   <= 1'b0;
      flag_q  <= 1'b0;
      code_q  <= EV_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      hit_q   <= hit_d;
      flag_q  <= flag_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_hit   = hit_q;
  assign o_flag  = flag_q;
  assign o_code  = code_q;
  assign o_cnt   = cnt_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// Directed table-driven bench for seq_det_fsm.
// Small counter width so saturation is reachable.
module tb_seq_det_fsm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       i_vld;
  logic [0:0] i_sym;
  logic [3:0] cfg_pat;
  logic       cfg_overlap;
  logic       o_hit;
  logic       o_flag;
  logic [1:0] o_code;
  logic [1:0] o_cnt;
  logic [1:0] o_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       vld;
    logic       sym;
    logic [3:0] pat;
    logic       ovl;
    logic       hit;
    logic       flag;
    logic [1:0] code;
    logic [1:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  seq_det_fsm #(
    .SYM_W    (1),
    .PAT_LEN  (4),
    .HOLD_CYC (2),
    .CNT_W    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .i_vld       (i_vld),
    .i_sym       (i_sym),
    .cfg_pat     (cfg_pat),
    .cfg_overlap (cfg_overlap),
    .o_hit       (o_hit),
    .o_flag      (o_flag),
    .o_code      (o_code),
    .o_cnt       (o_cnt),
    .o_state     (o_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic c, input logic v,
                     input logic s, input logic [3:0] p, input logic o,
                     input logic h, input logic f, input logic [1:0] cd,
                     input logic [1:0] cn, input logic [1:0] st);
    vec_t r;
    r.en = e; r.clr = c; r.vld = v; r.sym = s; r.pat = p; r.ovl = o;
    r.hit = h; r.flag = f; r.code = cd; r.cnt = cn; r.st = st;
    vecs.push_back(r);
  endtask

  task automatic apply(input vec_t v, input string tag);
    en          = v.en;
    clr         = v.clr;
    i_vld       = v.vld;
    i_sym       = v.sym;
    cfg_pat     = v.pat;
    cfg_overlap = v.ovl;
    @(posedge clk);
    #1;
    chk({tag, " hit"},   int'(o_hit),   int'(v.hit));
    chk({tag, " flag"},  int'(o_flag),  int'(v.flag));
    chk({tag, " code"},  int'(o_code),  int'(v.code));
    chk({tag, " cnt"},   int'(o_cnt),   int'(v.cnt));
    chk({tag, " state"}, int'(o_state), int'(v.st));
  endtask

  localparam logic [3:0] P1011 = 4'b1011;
  localparam logic [3:0] P1010 = 4'b1010;
  localparam logic [3:0] P1111 = 4'b1111;

  initial begin
    vec_t r;
    // case 1 then hold expiry into SCAN
    add(1,0,0,0,P1011,1, 0,0,0,0,1);
    add(1,0,1,1,P1011,1, 0,0,0,0,1);
    add(1,0,1,0,P1011,1, 0,0,0,0,1);
    add(1,0,1,1,P1011,1, 0,0,0,0,1);
    add(1,0,1,1,P1011,1, 1,1,1,1,3);
    add(1,0,1,0,P1011,1, 0,1,0,1,3);
    add(1,0,1,0,P1011,1, 0,0,3,1,2);
    add(1,0,0,0,P1011,1, 0,0,0,1,2);
    // overlapping 1010 with retrigger on the expiring symbol
    add(1,1,1,1,P1010,1, 0,0,0,0,1);
    add(1,0,1,1,P1010,1, 0,0,0,0,1);
    add(1,0,1,0,P1010,1, 0,0,0,0,1);
    add(1,0,1,1,P1010,1, 0,0,0,0,1);
    add(1,0,1,0,P1010,1, 1,1,1,1,3);
    add(1,0,1,1,P1010,1, 0,1,0,1,3);
    add(1,0,1,0,P1010,1, 1,1,2,2,3);
    // non-overlapping 1010
    add(1,1,0,0,P1010,0, 0,0,0,0,1);
    add(1,0,1,1,P1010,0, 0,0,0,0,1);
    add(1,0,1,0,P1010,0, 0,0,0,0,1);
    add(1,0,1,1,P1010,0, 0,0,0,0,1);
    add(1,0,1,0,P1010,0, 1,1,1,1,3);
    add(1,0,1,1,P1010,0, 0,1,0,1,3);
    add(1,0,1,0,P1010,0, 0,0,3,1,1);
    // clr drops its symbol; case 1 with 3-cycle gaps
    add(1,1,1,0,P1011,0, 0,0,0,0,1);
    add(1,0,1,1,P1011,0, 0,0,0,0,1);
    for (int i = 0; i < 3; i++) add(1,0,0,1,P1011,0, 0,0,0,0,1);
    add(1,0,1,0,P1011,0, 0,0,0,0,1);
    for (int i = 0; i < 3; i++) add(1,0,0,1,P1011,0, 0,0,0,0,1);
    add(1,0,1,1,P1011,0, 0,0,0,0,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,P1011,0, 0,0,0,0,1);
    add(1,0,1,1,P1011,0, 1,1,1,1,3);
    for (int i = 0; i < 3; i++) add(1,0,0,1,P1011,0, 0,1,0,1,3);
    // en low keeps count; IDLE drops the offered symbol
    add(0,0,1,1,P1011,0, 0,0,0,1,0);
    add(1,0,1,1,P1011,0, 0,0,0,1,1);
    add(1,0,1,0,P1011,0, 0,0,0,1,1);
    add(1,0,1,1,P1011,0, 0,0,0,1,1);
    add(1,0,1,1,P1011,0, 0,0,0,1,1);
    add(1,0,1,1,P1011,0, 0,0,0,1,2);
    add(1,0,1,0,P1011,0, 0,0,0,1,2);
    add(1,0,1,1,P1011,0, 0,0,0,1,2);
    add(1,0,1,1,P1011,0, 1,1,1,2,3);
    // counter saturation with seven 1s
    add(1,1,0,0,P1111,1, 0,0,0,0,1);
    add(1,0,1,1,P1111,1, 0,0,0,0,1);
    add(1,0,1,1,P1111,1, 0,0,0,0,1);
    add(1,0,1,1,P1111,1, 0,0,0,0,1);
    add(1,0,1,1,P1111,1, 1,1,1,1,3);
    add(1,0,1,1,P1111,1, 1,1,2,2,3);
    add(1,0,1,1,P1111,1, 1,1,2,3,3);
    add(1,0,1,1,P1111,1, 1,1,2,3,3);
    add(1,1,0,0,P1111,1, 0,0,0,0,1);

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; i_vld = 1'b0;
    i_sym = '0; cfg_pat = P1011; cfg_overlap = 1'b1;
    #12;
    chk("rst hit",   int'(o_hit),   0);
    chk("rst flag",  int'(o_flag),  0);
    chk("rst code",  int'(o_code),  0);
    chk("rst cnt",   int'(o_cnt),   0);
    chk("rst state", int'(o_state), 0);
    #11 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // async reset mid-HOLD, between edges
    for (int i = 0; i < 3; i++) begin
      r = vecs[0]; r.pat = P1111; r.vld = 1; r.sym = 1;
      r.hit = 0; r.flag = 0; r.code = 0; r.cnt = 0; r.st = 1;
      apply(r, $sformatf("pre%0d", i));
    end
    r.hit = 1; r.flag = 1; r.code = 1; r.cnt = 1; r.st = 3;
    apply(r, "pre3");
    #3 rst_n = 1'b0;
    #1;
    chk("arst flag",  int'(o_flag),  0);
    chk("arst cnt",   int'(o_cnt),   0);
    chk("arst state", int'(o_state), 0);
    chk("arst hit",   int'(o_hit),   0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      apply(vecs[i], $sformatf("replay%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
